// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide, BITS_PER_CYCLE bits per CALC cycle.
module mdu_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int RADDR_W        = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         op_i,
    input  logic [XLEN-1:0]    rs1_i,
    input  logic [XLEN-1:0]    rs2_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               flush_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [XLEN-1:0]    result_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               busy_o
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [XLEN-1:0]    hi, lo, opnd, res_q;
    logic [RADDR_W-1:0] tag_q;

    logic            accept, is_div, a_sgn, b_sgn, neg_a, neg_b;
    logic            div0, ovf, fast;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign req_ready_o = (state == IDLE) && rst && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

    assign is_div = op_i[2];
    assign a_sgn  = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    assign b_sgn  = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    assign neg_a  = a_sgn & rs1_i[XLEN-1];
    assign neg_b  = b_sgn & rs2_i[XLEN-1];
    assign mag_a  = neg_a ? -rs1_i : rs1_i;
    assign mag_b  = neg_b ? -rs2_i : rs2_i;
    assign div0   = is_div && (rs2_i == '0);
    assign ovf    = is_div && !op_i[0] && (rs2_i == '1)
                    && (rs1_i == {1'b1, {(XLEN-1){1'b0}}});
    assign fast   = div0 || ovf;

    // Results that bypass the iteration entirely
    always_comb begin
        fast_res = '0;
        if (div0)
            fast_res = op_i[1] ? rs1_i : '1;
        else
            fast_res = op_i[1] ? '0 : rs1_i;
    end

    logic [XLEN-1:0] h, l;
    logic [XLEN:0]   t, s;

    always_comb begin
        h = hi;
        l = lo;
        t = '0;
        s = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                t = {h, l[XLEN-1]};
                l = {l[XLEN-2:0], 1'b0};
                if (t >= {1'b0, opnd}) begin
                    t    = t - {1'b0, opnd};
                    l[0] = 1'b1;
                end
                h = t[XLEN-1:0];
            end else begin
                s = {1'b0, h} + (l[0] ? {1'b0, opnd} : '0);
                l = {s[0], l[XLEN-1:1]};
                h = s[XLEN:1];
            end
        end
    end

    // Sign fix-up applied to the final step's output
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin;

    assign prod   = {h, l};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -l : l;
    assign rem_s  = neg_q ? -h : h;

    always_comb begin
        fin = '0;
        if (op_q[2])
            fin = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'd0)
            fin = prod_s[XLEN-1:0];
        else
            fin = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = fast ? DONE : CALC;
            CALC:    if (flush_i) state_n = IDLE;
                     else if (cnt == ONE) state_n = DONE;
            DONE:    if (flush_i || res_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            res_q <= '0;
            tag_q <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: if (accept) begin
                    op_q  <= op_i;
                    tag_q <= rd_addr_i;
                    cnt   <= fast ? '0 : N_CNT;
                    neg_q <= (op_i[2] && op_i[1]) ? neg_a : (neg_a ^ neg_b);
                    hi    <= '0;
                    lo    <= is_div ? mag_a : mag_b;
                    opnd  <= is_div ? mag_b : mag_a;
                    res_q <= fast_res;
                end
                CALC: begin
                    hi  <= h;
                    lo  <= l;
                    cnt <= cnt - ONE;
                    if (cnt == ONE) res_q <= fin;
                end
                default: ;
            endcase
        end
    end

    assign res_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign result_o    = res_valid_o ? res_q : '0;
    assign rd_addr_o   = res_valid_o ? tag_q : '0;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: BPC=1 and BPC=4 instances on shared stimulus,
// vector table plus random model-checked ops and handshake/flush/reset sequences.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        res_ready = 1'b1;

    logic        ready1, valid1, busy1;
    logic [31:0] result1;
    logic [4:0]  tag1;
    logic        ready4, valid4, busy4;
    logic [31:0] result4;
    logic [4:0]  tag4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .RADDR_W(5)) dut1 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_addr_i(rd_addr),
        .flush_i(flush), .res_valid_o(valid1), .res_ready_i(res_ready),
        .result_o(result1), .rd_addr_o(tag1), .busy_o(busy1)
    );

    mdu_iter #(.XLEN(32), .BITS_PER_CYCLE(4), .RADDR_W(5)) dut4 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(ready4),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_addr_i(rd_addr),
        .flush_i(flush), .res_valid_o(valid4), .res_ready_i(1'b1),
        .result_o(result4), .rd_addr_o(tag4), .busy_o(busy4)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        logic signed [31:0] x, y;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        x  = a;
        y  = b;
        p  = '0;
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                  else return x / y;
            3'd5: if (b == 0) return 32'hFFFFFFFF; else return a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                  else return x % y;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    // Drive one op to both units and score result, tag and latency
    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input logic [4:0] t);
        exp_t x;
        int l1, l4;
        logic [31:0] r1, r4;
        logic [4:0] g1, g4;
        bit f;
        f = o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
        x.res = e;
        x.tag = t;
        x.lat = f ? 1 : 33;
        q1.push_back(x);
        x.lat = f ? 1 : 9;
        q4.push_back(x);
        op = o; rs1 = a; rs2 = b; rd_addr = t; req_valid = 1'b1;
        l1 = 0; l4 = 0; r1 = '0; r4 = '0; g1 = '0; g4 = '0;
        for (int c = 1; c <= 60 && (l1 == 0 || l4 == 0); c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                req_valid = 1'b0;
                check("busy_after_accept", busy1, 1'b1);
            end
            if (valid1 && l1 == 0) begin l1 = c; r1 = result1; g1 = tag1; end
            if (valid4 && l4 == 0) begin l4 = c; r4 = result4; g4 = tag4; end
        end
        x = q1.pop_front();
        check($sformatf("res1 op%0d %0h,%0h", o, a, b), r1, x.res);
        check("tag1", g1, x.tag);
        check($sformatf("lat1 op%0d", o), l1, x.lat);
        x = q4.pop_front();
        check($sformatf("res4 op%0d %0h,%0h", o, a, b), r4, x.res);
        check("tag4", g4, x.tag);
        check($sformatf("lat4 op%0d", o), l4, x.lat);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid1();
        for (int c = 0; c < 60 && !valid1; c++) begin
            @(posedge clk); #1;
        end
        check("wait_valid1", valid1, 1'b1);
    endtask

    vec_t vt[12];
    bit seen;

    initial begin
        vt[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB};
        vt[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE};
        vt[2]  = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF};
        vt[3]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000};
        vt[4]  = '{3'd4, 32'd7,          32'd0,        32'hFFFFFFFF};
        vt[5]  = '{3'd7, 32'd7,          32'd0,        32'd7};
        vt[6]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
        vt[7]  = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0};
        vt[8]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD};
        vt[9]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF};
        vt[10] = '{3'd5, 32'd100,        32'd7,        32'd14};
        vt[11] = '{3'd7, 32'd100,        32'd7,        32'd2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_ready", ready1, 1'b0);
        check("rst_result", result1, 32'd0);
        check("rst_tag", tag1, 5'd0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", ready1, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 5'(i + 1));

        for (int i = 0; i < 10; i++) begin
            logic [2:0] o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run(o, a, b, model(o, a, b), 5'($urandom_range(0, 31)));
        end

        // Result held while consumer stalls; no accept on the consume edge
        res_ready = 1'b0;
        op = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; rd_addr = 5'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_valid1();
        check("hold_res0", result1, 32'hFFFFFFEB);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold_valid", valid1, 1'b1);
            check("hold_res", result1, 32'hFFFFFFEB);
            check("hold_tag", tag1, 5'd9);
            check("hold_ready", ready1, 1'b0);
        end
        op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd3; req_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("consume_valid", valid1, 1'b0);
        check("consume_busy", busy1, 1'b0);
        check("consume_result", result1, 32'd0);
        check("consume_tag", tag1, 5'd0);
        check("consume_ready", ready1, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("accept_next_edge", busy1, 1'b1);
        wait_valid1();
        check("divu_after_hold", result1, 32'd14);
        check("divu_after_hold_tag", tag1, 5'd3);
        @(posedge clk); #1;

        // Flush in IDLE blocks acceptance
        flush = 1'b1; req_valid = 1'b1; op = 3'd0;
        #1;
        check("flush_idle_ready", ready1, 1'b0);
        @(posedge clk); #1;
        check("flush_idle_busy", busy1, 1'b0);
        flush = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;

        // Flush mid-CALC of a DIVU
        seen = 1'b0;
        op = 3'd5; rs1 = 32'hFFFF0000; rs2 = 32'd3; rd_addr = 5'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #1;
            if (valid1) seen = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy1, 1'b0);
        check("flush_valid", valid1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid1) seen = 1'b1;
        end
        check("flush_no_result", seen, 1'b0);

        // Reset mid-CALC of a MUL
        op = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; rd_addr = 5'd2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("rst_mid_ready", ready1, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_busy", busy1, 1'b0);
        check("rst_mid_valid", valid1, 1'b0);
        check("rst_mid_result", result1, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_ready_back", ready1, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid1) seen = 1'b1;
        end
        check("rst_no_result", seen, 1'b0);

        run(3'd5, 32'd100, 32'd7, 32'd14, 5'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
